// File: rtl/reg8_serial_tx_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package reg8_serial_tx_pkg;

  // Default word width, matching the datapath's 8-bit registers.
  localparam int DEFAULT_WIDTH = 8;

  // Transmitter control states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit-counter width. It counts 0..width-1, and it is never narrower than 1 bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/reg8_serial_tx_piso_shift_reg.sv
// Loadable shift register with a selectable output end. Load has priority over
// shift, so a reload on the final transfer overwrites the shift that would
// otherwise happen in that cycle.
module piso_shift_reg
  import reg8_serial_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             bit_out
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  // The next value after one shift toward the output end, with zero fill.
  always_comb begin
    w_shifted = '0;
    if (MSB_FIRST) begin
      w_shifted = {r_q[WIDTH-2:0], 1'b0};
    end else begin
      w_shifted = {1'b0, r_q[WIDTH-1:1]};
    end
  end

  // Storage: reset clears, load captures the word, shift advances one bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      r_q <= w_shifted;
    end
  end

  assign q       = r_q;
  assign bit_out = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: rtl/reg8_serial_tx.sv
// Read-out end of the register path. It accepts a parallel word when it is free,
// or on the cycle its final bit is accepted, and sends the word out one bit per
// serial handshake.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no word held; load_ready=1, ser_valid=0
//   ST_SHIFT | word in flight; ser_valid=1, busy=1, bit counter tracks position
module reg8_serial_tx
  import reg8_serial_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_done;

  logic              w_in_shift;
  logic              w_last;
  logic              w_xfer;
  logic              w_load;
  logic              w_ser_bit;
  logic [WIDTH-1:0]  w_sreg_q_unused;

  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_last     = w_in_shift && (r_cnt == LAST_CNT);
  assign w_xfer     = w_in_shift && ser_ready;

  // load_ready looks only at state and ser_ready, so it never forms a loop
  // with the upstream load_valid.
  assign load_ready = !w_in_shift || (w_last && ser_ready);
  assign w_load     = load_valid && load_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode. A reload on the last transfer keeps SHIFT, which gives
  // back-to-back words with no gap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_xfer && w_last && !load_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit position counter. It returns to 0 on the last transfer so that it
  // never runs past WIDTH-1, even when WIDTH is not a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // One-cycle completion pulse after the final bit is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;
    end
  end

  // The full register contents are not needed here. Only the output-end bit is used.
  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .shift   (w_xfer),
    .d       (din),
    .q       (w_sreg_q_unused),
    .bit_out (w_ser_bit)
  );

  assign ser_out   = w_ser_bit;
  assign ser_valid = w_in_shift;
  assign busy      = w_in_shift;
  assign ser_last  = w_last;
  assign done      = r_done;

endmodule

// File: doc/reg8_serial_tx.md
# reg8_serial_tx

Parallel-in/serial-out transmitter that reads an 8-bit word from the datapath's 8-bit enable-loaded registers (e.g. the ALU result register) and shifts it out one bit per accepted transfer, with a valid/ready handshake on both sides. It is the read-out end of the register path. The load side accepts a word only when the transmitter can take it. The serial side supports back-pressure and a zero-bubble reload on the last bit.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.

- `clk`  input  1  clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `load_valid`  input  1  `din` holds a word to transmit.
- `load_ready`  output  1  transmitter can accept a word this cycle.
- `din`  input  WIDTH  parallel word, captured when `load_valid && load_ready`.
- `ser_valid`  output  1  `ser_out` holds a valid bit.
- `ser_ready`  input  1  consumer accepts `ser_out` this cycle.
- `ser_out`  output  1  current serial bit.
- `ser_last`  output  1  current bit is the final bit of the word.
- `busy`  output  1  a word is in flight (state SHIFT).
- `done`  output  1  one-cycle pulse, registered, in the cycle after the last bit is accepted.

## Operation
- FSM states:
  - IDLE: `load_ready`=1, `ser_valid`=0.
  - SHIFT: `ser_valid`=1, `busy`=1.
- IDLE → SHIFT on load handshake (`load_valid && load_ready`):
  - `din` is captured into the shift register.
  - Bit counter is set to 0.
- A bit transfer occurs when `ser_valid && ser_ready`. On each transfer in SHIFT:
  - Shift register shifts by one toward the output end.
  - Counter increments.
- `ser_out` is the output-end bit of the shift register:
  - `MSB_FIRST`=1: `sreg[WIDTH-1]`, shifting left with 0 fill.
  - `MSB_FIRST`=0: `sreg[0]`, shifting right with 0 fill.
- `ser_last` = SHIFT && counter == WIDTH-1.
- On the transfer with `ser_last`=1:
  - If `load_valid`=1: reload `din`, reset counter to 0, remain in SHIFT (zero bubble).
  - Otherwise: go to IDLE.
  - `done` pulses in the next cycle in both cases.
- `load_ready` = IDLE || (SHIFT && `ser_last` && `ser_ready`). It is combinational from state and `ser_ready`. `load_ready` must not depend on `load_valid`.
- `ser_ready` low in SHIFT: state, counter, shift register and `ser_out` hold; `ser_valid` stays 1.
- `load_valid` while in SHIFT and not on the last transfer: ignored, because `load_ready`=0. The upstream register keeps the word.
- Counter width is clog2(WIDTH). It is never compared beyond WIDTH-1 and never wraps mid-word.
- Reset values:
  - state IDLE; shift register 0; counter 0.
  - `ser_out`=0, `ser_valid`=0, `ser_last`=0, `busy`=0, `done`=0.
  - `load_ready`=1.
- Reset asserted mid-word aborts it immediately. Remaining bits are discarded and no `done` pulse is produced.

## Timing
- Load handshake at edge N: `ser_valid`=1 and the first bit appear after edge N.
- With `ser_ready` held high, one word takes exactly WIDTH cycles. Back-to-back words have no idle cycle.
- `done` is high for exactly one cycle, after the edge that accepted the last bit.
- All outputs except `load_ready` are registered or decoded from registered state only.
- Combinational paths:
  - `load_ready` depends combinationally on `ser_ready`.
  - There is no combinational path from `load_valid` or `din` to any output.

## Structure
- Shared package contents:
  - state type (IDLE, SHIFT).
  - default `WIDTH` constant (8).
  - counter width function (clog2).
- Sub-module `piso_shift_reg`:
  - WIDTH-bit register with async active-high reset.
  - controls: `load`, `shift`, direction parameter.
  - outputs: `q` and output-end bit.
- The top level holds the FSM, counter, handshake and `done` logic.

## Test plan
- After reset, `din`=8'hA5 with `load_valid` pulsed one cycle and `ser_ready`=1 → `ser_out` sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles. `ser_last` is high on the 8th bit only, then `done` pulses once and `load_ready` returns to 1.
- `MSB_FIRST`=0, `din`=8'h01 → first bit 1, then seven 0s.
- Back-pressure: 8'hC3 with `ser_ready` toggled 1,0,0,1,... → `ser_out`, `ser_last` and counter hold while `ser_ready`=0. The bit sequence is unchanged (1,1,0,0,0,0,1,1).
- Zero-bubble reload: words 8'hFF then 8'h00 with `load_valid` held high → 16 contiguous valid bits (eight 1s, then eight 0s). `load_ready`=1 only on the last-bit cycles, `busy` never drops, and `done` pulses twice.
- `load_valid` asserted with 8'h55 mid-word → ignored. The current word completes intact and 8'h55 is accepted only at the last-bit transfer.
- `rst` asserted at bit 4 of 8'h3C → all outputs take their reset values without waiting for a clock edge, with no `done` pulse. A following 8'h81 transmits correctly from its first bit.
